branch_target_buffer_pred: RTL and testbench

Parametrised fully-associative branch target buffer with per-entry saturating direction counters and round-robin replacement. It sits between IF and EXEC. IF performs a same-cycle lookup on `pc_i` to get a predicted next PC. EXEC reports resolved control-flow instructions, which train the counters and allocate entries. When every row is valid, allocation evicts the row at a wrapping victim pointer; a full table is never an error.

---
 rtl/branch_target_buffer_pred_pkg.sv | 14 +
 rtl/branch_target_buffer_pred_if.sv | 24 ++
 rtl/priority_encoder.sv | 23 ++
 rtl/branch_target_buffer_pred.sv | 125 ++++++++++++
 tb/tb_branch_target_buffer_pred.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_target_buffer_pred_pkg.sv
// rtl/branch_target_buffer_pred_pkg.sv - shared core types for the branch target buffer
package branch_target_buffer_pred_pkg;

    typedef logic [63:0] addr_t;
    typedef logic [61:0] word_t;

    localparam int ADDR_LSB = 2;

    // Instruction-word portion of an address; the byte offset is never stored.
    function automatic word_t addr_word(addr_t a);
        return a[63:ADDR_LSB];
    endfunction

endpackage

// File: rtl/branch_target_buffer_pred_if.sv
// rtl/branch_target_buffer_pred_if.sv - IF lookup and EXEC update bundle for the BTB
interface branch_target_buffer_pred_if;
    import branch_target_buffer_pred_pkg::*;

    addr_t pc_i;
    logic  hit_o;
    logic  predict_taken_o;
    addr_t next_pc_o;
    logic  upd_valid_i;
    addr_t upd_pc_i;
    addr_t upd_target_i;
    logic  upd_taken_i;

    modport master (
        output pc_i, upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
        input  hit_o, predict_taken_o, next_pc_o
    );

    modport slave (
        input  pc_i, upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
        output hit_o, predict_taken_o, next_pc_o
    );

endinterface

// File: rtl/priority_encoder.sv
// rtl/priority_encoder.sv - lowest-set-bit index finder used for row searches
module priority_encoder #(
    parameter int N = 4
) (
    input  logic [N-1:0]                        i_req,
    output logic                                o_found,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] o_idx
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Scan downward so the lowest requesting index is the last to be written.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_found = 1'b1;
                o_idx   = i[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/branch_target_buffer_pred.sv
// rtl/branch_target_buffer_pred.sv - fully-associative BTB with saturating direction counters
module branch_target_buffer_pred
    import branch_target_buffer_pred_pkg::*;
#(
    parameter int NUM_ROWS = 256,
    parameter int CTR_W    = 2
) (
    input  logic                              clk_i,
    input  logic                              arst_ni,
    input  logic                              flush_i,
    branch_target_buffer_pred_if.slave        bus,
    output logic                              table_update_o,
    output logic                              full_o
);
    localparam int IDX_W = $clog2(NUM_ROWS);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

    logic [NUM_ROWS-1:0] r_valid;
    word_t               r_tag    [NUM_ROWS];
    word_t               r_target [NUM_ROWS];
    logic [CTR_W-1:0]    r_ctr    [NUM_ROWS];
    logic [IDX_W-1:0]    r_victim;
    logic                r_full;

    logic [NUM_ROWS-1:0] w_lk_match;
    logic [NUM_ROWS-1:0] w_up_match;
    logic                w_lk_found, w_up_found, w_inv_found;
    logic [IDX_W-1:0]    w_lk_idx, w_up_idx, w_inv_idx;
    logic                w_do_update, w_evict;
    logic [IDX_W-1:0]    w_wr_idx;
    logic [CTR_W-1:0]    w_ctr_cur, w_ctr_next;
    logic                w_unused;

    assign w_unused = ^{bus.upd_pc_i[1:0], bus.upd_target_i[1:0]};

    always_comb begin
        w_lk_match = '0;
        w_up_match = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            w_lk_match[i] = r_valid[i] && (r_tag[i] == addr_word(bus.pc_i));
            w_up_match[i] = r_valid[i] && (r_tag[i] == addr_word(bus.upd_pc_i));
        end
    end

    priority_encoder #(.N(NUM_ROWS)) u_lk_enc (
        .i_req   (w_lk_match),
        .o_found (w_lk_found),
        .o_idx   (w_lk_idx)
    );

    priority_encoder #(.N(NUM_ROWS)) u_up_enc (
        .i_req   (w_up_match),
        .o_found (w_up_found),
        .o_idx   (w_up_idx)
    );

    priority_encoder #(.N(NUM_ROWS)) u_inv_enc (
        .i_req   (~r_valid),
        .o_found (w_inv_found),
        .o_idx   (w_inv_idx)
    );

    assign bus.hit_o           = w_lk_found;
    assign bus.predict_taken_o = w_lk_found && r_ctr[w_lk_idx][CTR_W-1];
    assign bus.next_pc_o       = bus.predict_taken_o ? {r_target[w_lk_idx], 2'b00}
                                                     : bus.pc_i + 64'd4;

    // A not-taken miss has nothing to train or allocate, so it writes nothing.
    assign w_do_update    = bus.upd_valid_i && !flush_i && (w_up_found || bus.upd_taken_i);
    assign w_evict        = w_do_update && !w_up_found && !w_inv_found;
    assign w_wr_idx       = w_up_found  ? w_up_idx  :
                            w_inv_found ? w_inv_idx : r_victim;
    assign table_update_o = w_do_update;
    assign full_o         = r_full;

    always_comb begin
        w_ctr_cur  = r_ctr[w_up_idx];
        w_ctr_next = CTR_WEAK;
        if (w_up_found) begin
            if (bus.upd_taken_i) begin
                w_ctr_next = (w_ctr_cur == CTR_MAX) ? w_ctr_cur : w_ctr_cur + CTR_W'(1);
            end else begin
                w_ctr_next = (w_ctr_cur == '0) ? w_ctr_cur : w_ctr_cur - CTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_valid  <= '0;
            r_victim <= '0;
            r_full   <= 1'b0;
            for (int i = 0; i < NUM_ROWS; i++) begin
                r_ctr[i] <= '0;
            end
        end else begin
            // Lags the valid bits by one cycle.
            r_full <= &r_valid;
            if (flush_i) begin
                r_valid  <= '0;
                r_victim <= '0;
            end else if (w_do_update) begin
                r_valid[w_wr_idx] <= 1'b1;
                r_ctr[w_wr_idx]   <= w_ctr_next;
                if (w_evict) begin
                    r_victim <= r_victim + IDX_W'(1);
                end
            end
        end
    end

    // Tag and target are qualified by valid, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (w_do_update) begin
            if (!w_up_found) begin
                r_tag[w_wr_idx]    <= addr_word(bus.upd_pc_i);
                r_target[w_wr_idx] <= addr_word(bus.upd_target_i);
            end else if (bus.upd_taken_i) begin
                r_target[w_wr_idx] <= addr_word(bus.upd_target_i);
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer_pred.sv
// tb/tb_branch_target_buffer_pred.sv - randomized BTB bench against a behavioural table model
module tb_branch_target_buffer_pred;
    import branch_target_buffer_pred_pkg::*;

    localparam int N     = 4;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int CHALF = 1 << (CW - 1);

    logic clk;
    logic arst_ni;
    logic flush;
    logic table_update;
    logic full;

    branch_target_buffer_pred_if bus_if ();

    branch_target_buffer_pred #(.NUM_ROWS(N), .CTR_W(CW)) dut (
        .clk_i          (clk),
        .arst_ni        (arst_ni),
        .flush_i        (flush),
        .bus            (bus_if),
        .table_update_o (table_update),
        .full_o         (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Behavioural table: what each row holds, in plain integers.
    bit          m_valid  [N];
    logic [61:0] m_tag    [N];
    logic [61:0] m_target [N];
    int          m_ctr    [N];
    int          m_victim = 0;
    bit          m_full   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_find(input addr_t a);
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && m_tag[i] == a[63:2]) return i;
        end
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 0;
        end
        m_victim = 0;
        m_full   = 0;
    endtask

    always @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            m_reset();
        end else begin
            int  h, r;
            bit  all_v;
            all_v = 1;
            for (int i = 0; i < N; i++) all_v &= m_valid[i];
            if (flush) begin
                for (int i = 0; i < N; i++) m_valid[i] = 0;
                m_victim = 0;
            end else if (bus_if.upd_valid_i) begin
                h = m_find(bus_if.upd_pc_i);
                if (h >= 0) begin
                    if (bus_if.upd_taken_i) begin
                        if (m_ctr[h] < CMAX) m_ctr[h]++;
                        m_target[h] = bus_if.upd_target_i[63:2];
                    end else if (m_ctr[h] > 0) begin
                        m_ctr[h]--;
                    end
                end else if (bus_if.upd_taken_i) begin
                    r = -1;
                    for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) r = i;
                    if (r < 0) begin
                        r = m_victim;
                        m_victim = (m_victim + 1) % N;
                    end
                    m_valid[r]  = 1;
                    m_tag[r]    = bus_if.upd_pc_i[63:2];
                    m_target[r] = bus_if.upd_target_i[63:2];
                    m_ctr[r]    = CHALF;
                end
            end
            m_full = all_v;
        end
    end

    int    c_h;
    bit    c_taken;
    addr_t c_next;
    bit    c_upd;

    always @(negedge clk) begin
        c_h     = m_find(bus_if.pc_i);
        c_taken = (c_h >= 0) && (m_ctr[c_h] >= CHALF);
        c_next  = c_taken ? {m_target[c_h], 2'b00} : bus_if.pc_i + 64'd4;
        c_upd   = bus_if.upd_valid_i && !flush &&
                  ((m_find(bus_if.upd_pc_i) >= 0) || bus_if.upd_taken_i);
        chk("model_hit",    {63'd0, bus_if.hit_o},           {63'd0, c_h >= 0});
        chk("model_taken",  {63'd0, bus_if.predict_taken_o}, {63'd0, c_taken});
        chk("model_nextpc", bus_if.next_pc_o,                c_next);
        chk("model_update", {63'd0, table_update},           {63'd0, c_upd});
        chk("model_full",   {63'd0, full},                   {63'd0, m_full});
    end

    task automatic drive(input bit fl, input bit uv, input addr_t up, input addr_t ut,
                         input bit tk, input addr_t pc);
        flush               = fl;
        bus_if.upd_valid_i  = uv;
        bus_if.upd_pc_i     = up;
        bus_if.upd_target_i = ut;
        bus_if.upd_taken_i  = tk;
        bus_if.pc_i         = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input addr_t pc, input bit eh, input bit et, input addr_t en,
                        input int ef = -1);
        drive(0, 0, 64'd0, 64'd0, 0, pc);
        @(negedge clk);
        chk("lit_hit",    {63'd0, bus_if.hit_o},           {63'd0, eh});
        chk("lit_taken",  {63'd0, bus_if.predict_taken_o}, {63'd0, et});
        chk("lit_nextpc", bus_if.next_pc_o,                en);
        if (ef >= 0) chk("lit_full", {63'd0, full}, 64'(ef));
        tick();
    endtask

    task automatic upd(input addr_t pc, input addr_t tgt, input bit tk, input bit eu);
        drive(0, 1, pc, tgt, tk, 64'd0);
        @(negedge clk);
        chk("lit_update", {63'd0, table_update}, {63'd0, eu});
        tick();
    endtask

    function automatic addr_t pool_pc();
        return 64'h100 + 64'(16 * $urandom_range(0, 9)) + 64'($urandom_range(0, 3));
    endfunction

    addr_t r_up, r_pc;

    initial begin
        arst_ni = 1'b0;
        drive(0, 0, 64'd0, 64'd0, 0, 64'h1000);
        tick();
        tick();
        arst_ni = 1'b1;

        look(64'h1000, 0, 0, 64'h1004, 0);

        upd(64'h1000, 64'h2000, 1, 1);
        look(64'h1000, 1, 1, 64'h2000);
        upd(64'h1000, 64'h2000, 1, 1);
        look(64'h1000, 1, 1, 64'h2000);
        upd(64'h1000, 64'h9000, 0, 1);
        look(64'h1000, 1, 1, 64'h2000);
        upd(64'h1000, 64'h9000, 0, 1);
        look(64'h1000, 1, 0, 64'h1004);
        upd(64'h1000, 64'h9000, 0, 1);
        look(64'h1000, 1, 0, 64'h1004);
        upd(64'h1000, 64'h9000, 0, 1);
        look(64'h1000, 1, 0, 64'h1004);
        upd(64'h1000, 64'h3000, 1, 1);
        look(64'h1000, 1, 0, 64'h1004);
        upd(64'h1000, 64'h3000, 1, 1);
        look(64'h1000, 1, 1, 64'h3000);

        drive(1, 0, 64'd0, 64'd0, 0, 64'd0);
        tick();
        tick();

        for (int i = 1; i <= 4; i++) upd(addr_t'(16 * i), addr_t'(16 * i + 'h1000), 1, 1);
        look(64'h40, 1, 1, 64'h1040);
        look(64'h10, 1, 1, 64'h1010, 1);
        upd(64'h50, 64'h1050, 1, 1);
        look(64'h10, 0, 0, 64'h14);
        look(64'h50, 1, 1, 64'h1050);
        upd(64'h60, 64'h1060, 1, 1);
        look(64'h20, 0, 0, 64'h24);
        look(64'h30, 1, 1, 64'h1030);
        for (int i = 7; i <= 11; i++) upd(addr_t'(16 * i), addr_t'(16 * i + 'h1000), 1, 1);
        look(64'h70, 0, 0, 64'h74);
        look(64'h80, 1, 1, 64'h1080);
        look(64'hB0, 1, 1, 64'h10B0);

        upd(64'hC0, 64'h5000, 0, 0);
        look(64'hC0, 0, 0, 64'hC4, 1);

        drive(1, 1, 64'hD0, 64'h6000, 1, 64'h80);
        @(negedge clk);
        chk("lit_flush_update", {63'd0, table_update}, 64'd0);
        tick();
        look(64'hD0, 0, 0, 64'hD4);
        look(64'h80, 0, 0, 64'h84, 0);

        for (int i = 0; i < 4; i++) upd(addr_t'(16 * i + 'h200), addr_t'(16 * i + 'h3003), 1, 1);
        upd(64'h240, 64'h3040, 1, 1);
        look(64'h200, 0, 0, 64'h204);
        look(64'h213, 1, 1, 64'h3010);
        look(64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 64'h2);

        drive(0, 1, 64'h300, 64'h4000, 1, 64'h210);
        #2;
        arst_ni = 1'b0;
        tick();
        arst_ni = 1'b1;
        look(64'h300, 0, 0, 64'h304, 0);
        look(64'h210, 0, 0, 64'h214);

        for (int n = 0; n < 1500; n++) begin
            r_up = pool_pc();
            case ($urandom_range(0, 3))
                0:       r_pc = r_up;
                1:       r_pc = {$urandom, $urandom};
                default: r_pc = pool_pc();
            endcase
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6, r_up,
                  {$urandom, $urandom}, $urandom_range(0, 2) != 0, r_pc);
            tick();
        end

        drive(0, 0, 64'd0, 64'd0, 0, 64'd0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
